// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: EX/MEM/WB operand forwarding, load-use stalls, branch flushes, saturating perf counters.
// Controls are combinational from FSM state and inputs; mem_wait freezes everything, including the FSM and counters.
module hazard_control_unit #(
   parameter int LOAD_USE_STALLS     = 1,
   parameter int BRANCH_FLUSH_CYCLES = 1,
   parameter int CNT_W               = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       id_rn,
   input  logic [3:0]       id_rm,
   input  logic [3:0]       id_rd,
   input  logic             id_use_rn,
   input  logic             id_use_rm,
   input  logic             id_use_rd,
   input  logic [3:0]       ex_rd,
   input  logic             ex_rf_enable,
   input  logic             ex_load,
   input  logic [3:0]       mem_rd,
   input  logic             mem_rf_enable,
   input  logic [3:0]       wb_rd,
   input  logic             wb_rf_enable,
   input  logic             ex_branch_taken,
   input  logic             mem_wait,
   output logic             pc_enable,
   output logic             if_id_enable,
   output logic             if_id_flush,
   output logic             cu_mux_select,
   output logic             pipe_hold,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic [1:0]       fwd_c_sel,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;

   localparam logic [2:0] LU_RELOAD = 3'(LOAD_USE_STALLS - 1);
   localparam logic [2:0] BR_RELOAD = 3'(BRANCH_FLUSH_CYCLES - 1);

   state_t           state_q, state_d;
   logic [2:0]       remain_q, remain_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             lu, do_stall, do_flush;

   // A loading EX instruction has no result yet, so it never forwards; priority falls to MEM/WB.
   function automatic logic [1:0] fwd_sel(input logic [3:0] src);
      logic [1:0] sel;
      sel = 2'b00;
      if (src != 4'd15) begin
         if (ex_rf_enable && !ex_load && ex_rd == src)  sel = 2'b01;
         else if (mem_rf_enable && mem_rd == src)       sel = 2'b10;
         else if (wb_rf_enable && wb_rd == src)         sel = 2'b11;
      end
      return sel;
   endfunction

   assign lu = ex_load & ex_rf_enable & (ex_rd != 4'd15) &
               ((id_use_rn & (id_rn == ex_rd)) |
                (id_use_rm & (id_rm == ex_rd)) |
                (id_use_rd & (id_rd == ex_rd)));

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      do_stall = 1'b0;
      do_flush = 1'b0;
      if (!mem_wait) begin
         case (state_q)
            LU_STALL: begin
               do_stall = 1'b1;
               remain_d = remain_q - 3'd1;
               if (remain_q == 3'd1) state_d = RUN;
            end
            FLUSH: begin
               do_flush = 1'b1;
               if (ex_branch_taken) begin
                  remain_d = BR_RELOAD;
               end else begin
                  remain_d = remain_q - 3'd1;
                  if (remain_q == 3'd1) state_d = RUN;
               end
            end
            default: begin
               // A branch makes the ID instruction wrong-path, so it wins over load-use.
               if (ex_branch_taken) begin
                  do_flush = 1'b1;
                  if (BRANCH_FLUSH_CYCLES > 1) begin
                     state_d  = FLUSH;
                     remain_d = BR_RELOAD;
                  end
               end else if (lu) begin
                  do_stall = 1'b1;
                  if (LOAD_USE_STALLS > 1) begin
                     state_d  = LU_STALL;
                     remain_d = LU_RELOAD;
                  end
               end
            end
         endcase
      end
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (do_stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (do_flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_comb begin
      if (!reset) begin
         pc_enable     = 1'b0;
         if_id_enable  = 1'b0;
         if_id_flush   = 1'b1;
         cu_mux_select = 1'b1;
         pipe_hold     = 1'b0;
         fwd_a_sel     = 2'b00;
         fwd_b_sel     = 2'b00;
         fwd_c_sel     = 2'b00;
      end else begin
         pc_enable     = !mem_wait && !do_stall;
         if_id_enable  = !mem_wait && !do_stall && !do_flush;
         if_id_flush   = do_flush;
         cu_mux_select = do_stall || do_flush;
         pipe_hold     = mem_wait;
         fwd_a_sel     = fwd_sel(id_rn);
         fwd_b_sel     = fwd_sel(id_rm);
         fwd_c_sel     = fwd_sel(id_rd);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= RUN;
         remain_q    <= 3'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         remain_q    <= remain_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (default and 2-stall/3-flush/4-bit counters) checked against a
// pending-work model every negedge, plus directed literal checks.
module tb_hazard_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] id_rn, id_rm, id_rd, ex_rd, mem_rd, wb_rd;
   logic       id_use_rn, id_use_rm, id_use_rd;
   logic       ex_rf_enable, ex_load, mem_rf_enable, wb_rf_enable, ex_branch_taken, mem_wait;

   logic        u0_pc, u0_ifid, u0_fl, u0_cu, u0_ph;
   logic [1:0]  u0_fa, u0_fb, u0_fc;
   logic [15:0] u0_sc, u0_fcnt;
   logic        u1_pc, u1_ifid, u1_fl, u1_cu, u1_ph;
   logic [1:0]  u1_fa, u1_fb, u1_fc;
   logic [3:0]  u1_sc, u1_fcnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hazard_control_unit u0 (
      .clk(clk), .reset(reset),
      .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
      .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
      .ex_rd(ex_rd), .ex_rf_enable(ex_rf_enable), .ex_load(ex_load),
      .mem_rd(mem_rd), .mem_rf_enable(mem_rf_enable),
      .wb_rd(wb_rd), .wb_rf_enable(wb_rf_enable),
      .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
      .pc_enable(u0_pc), .if_id_enable(u0_ifid), .if_id_flush(u0_fl),
      .cu_mux_select(u0_cu), .pipe_hold(u0_ph),
      .fwd_a_sel(u0_fa), .fwd_b_sel(u0_fb), .fwd_c_sel(u0_fc),
      .stall_count(u0_sc), .flush_count(u0_fcnt)
   );

   hazard_control_unit #(.LOAD_USE_STALLS(2), .BRANCH_FLUSH_CYCLES(3), .CNT_W(4)) u1 (
      .clk(clk), .reset(reset),
      .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
      .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
      .ex_rd(ex_rd), .ex_rf_enable(ex_rf_enable), .ex_load(ex_load),
      .mem_rd(mem_rd), .mem_rf_enable(mem_rf_enable),
      .wb_rd(wb_rd), .wb_rf_enable(wb_rf_enable),
      .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
      .pc_enable(u1_pc), .if_id_enable(u1_ifid), .if_id_flush(u1_fl),
      .cu_mux_select(u1_cu), .pipe_hold(u1_ph),
      .fwd_a_sel(u1_fa), .fwd_b_sel(u1_fb), .fwd_c_sel(u1_fc),
      .stall_count(u1_sc), .flush_count(u1_fcnt)
   );

   // Model: outstanding bubbles/flush cycles still owed, plus plain integer event counts.
   typedef struct {
      int stall_left;
      int flush_left;
      int scnt;
      int fcnt;
   } mdl_t;

   localparam int M_RUN = 0, M_STALL = 1, M_FLUSH = 2, M_FREEZE = 3, M_RST = 4;
   localparam mdl_t ZERO = '{0, 0, 0, 0};

   mdl_t m0 = ZERO;
   mdl_t m1 = ZERO;

   function automatic logic lu_now();
      if (!(ex_load && ex_rf_enable) || ex_rd == 4'd15) return 1'b0;
      return (id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd) || (id_use_rd && id_rd == ex_rd);
   endfunction

   function automatic int mode(input mdl_t m);
      if (!reset)                             return M_RST;
      if (mem_wait)                           return M_FREEZE;
      if (m.stall_left > 0)                   return M_STALL;
      if (ex_branch_taken || m.flush_left > 0) return M_FLUSH;
      if (lu_now())                           return M_STALL;
      return M_RUN;
   endfunction

   function automatic mdl_t step(input mdl_t m, input int lus, input int bfc, input int cmax);
      mdl_t r;
      int   md;
      r  = m;
      md = mode(m);
      if (md == M_RST) return ZERO;
      if (md == M_STALL) begin
         r.stall_left = (m.stall_left > 0) ? m.stall_left - 1 : lus - 1;
         r.scnt       = (m.scnt < cmax) ? m.scnt + 1 : cmax;
      end
      if (md == M_FLUSH) begin
         r.flush_left = ex_branch_taken ? bfc - 1 : m.flush_left - 1;
         r.fcnt       = (m.fcnt < cmax) ? m.fcnt + 1 : cmax;
      end
      return r;
   endfunction

   function automatic logic [1:0] fwd_exp(input logic [3:0] src);
      logic [3:0] rds [3];
      logic       en  [3];
      rds[0] = ex_rd;  rds[1] = mem_rd;  rds[2] = wb_rd;
      en[0]  = ex_rf_enable && !ex_load;
      en[1]  = mem_rf_enable;
      en[2]  = wb_rf_enable;
      if (!reset || src == 4'd15) return 2'b00;
      for (int s = 0; s < 3; s++)
         if (en[s] && rds[s] == src) return 2'(s + 1);
      return 2'b00;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_dut(input string tag, input mdl_t m, input logic [10:0] act,
                          input logic [31:0] sc, input logic [31:0] fc);
      logic [4:0]  ctl;
      logic [10:0] exp;
      case (mode(m))
         M_RST:    ctl = 5'b00110;
         M_FREEZE: ctl = 5'b00001;
         M_STALL:  ctl = 5'b00010;
         M_FLUSH:  ctl = 5'b10110;
         default:  ctl = 5'b11000;
      endcase
      exp = {ctl, fwd_exp(id_rn), fwd_exp(id_rm), fwd_exp(id_rd)};
      check({tag, "_ctl_fwd"}, 32'(act), 32'(exp));
      check({tag, "_stall_count"}, sc, 32'(m.scnt));
      check({tag, "_flush_count"}, fc, 32'(m.fcnt));
   endtask

   always @(negedge clk) begin
      cmp_dut("u0", m0, {u0_pc, u0_ifid, u0_fl, u0_cu, u0_ph, u0_fa, u0_fb, u0_fc}, 32'(u0_sc), 32'(u0_fcnt));
      cmp_dut("u1", m1, {u1_pc, u1_ifid, u1_fl, u1_cu, u1_ph, u1_fa, u1_fb, u1_fc}, 32'(u1_sc), 32'(u1_fcnt));
   end

   task automatic cycle();
      @(posedge clk);
      m0 = step(m0, 1, 1, 65535);
      m1 = step(m1, 2, 3, 15);
      #1;
   endtask

   task automatic nop();
      {id_rn, id_rm, id_rd, ex_rd, mem_rd, wb_rd} = '0;
      {id_use_rn, id_use_rm, id_use_rd} = '0;
      {ex_rf_enable, ex_load, mem_rf_enable, wb_rf_enable, ex_branch_taken, mem_wait} = '0;
   endtask

   task automatic set_lu();
      nop();
      ex_rd = 4'd2; ex_rf_enable = 1'b1; ex_load = 1'b1;
      id_rm = 4'd2; id_use_rm = 1'b1;
   endtask

   task automatic drop_reset();
      reset = 1'b0;
      m0 = ZERO;
      m1 = ZERO;
   endtask

   function automatic logic [3:0] pick_reg();
      return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
   endfunction

   task automatic rand_inputs();
      id_rn = pick_reg(); id_rm = pick_reg(); id_rd = pick_reg();
      id_use_rn = 1'($urandom_range(0, 1));
      id_use_rm = 1'($urandom_range(0, 1));
      id_use_rd = 1'($urandom_range(0, 1));
      ex_rd = pick_reg();  ex_rf_enable  = ($urandom_range(0, 3) != 0);
      ex_load = ($urandom_range(0, 2) == 0);
      mem_rd = pick_reg(); mem_rf_enable = ($urandom_range(0, 1) != 0);
      wb_rd = pick_reg();  wb_rf_enable  = ($urandom_range(0, 1) != 0);
      // While a load-use bubble is pending EX holds a bubble, so no branch can be there.
      ex_branch_taken = ($urandom_range(0, 9) == 0) && m0.stall_left == 0 && m1.stall_left == 0;
      mem_wait = ($urandom_range(0, 7) == 0);
   endtask

   initial begin
      nop();
      drop_reset();
      #2;
      check("rst_pc", u0_pc, 0);
      check("rst_flush_cu", {u0_fl, u0_cu}, 2'b11);
      #1 reset = 1'b1;

      cycle();
      #1;
      check("nop_run", {u0_pc, u0_ifid, u0_fl, u0_cu, u0_ph}, 5'b11000);
      check("nop_counts", {u0_sc, u0_fcnt}, 0);

      set_lu();
      #1 check("lu_stall_ctl", {u0_pc, u0_ifid, u0_cu}, 3'b001);
      cycle();
      nop();
      mem_rd = 4'd2; mem_rf_enable = 1'b1; id_rm = 4'd2; id_use_rm = 1'b1;
      #1;
      check("lu_stall_count", u0_sc, 1);
      check("lu_then_fwd_b", u0_fb, 2'b10);
      check("lu_then_run", u0_pc, 1);
      cycle();

      nop();
      ex_rd = 4'd5; ex_rf_enable = 1'b1; mem_rd = 4'd5; mem_rf_enable = 1'b1;
      id_rn = 4'd5; id_rm = 4'd5; id_rd = 4'd15;
      #1 check("fwd_ex_prio", {u0_fa, u0_fb, u0_fc}, 6'b010100);
      ex_rf_enable = 1'b0;
      #1 check("fwd_mem", {u1_fa, u1_fb, u1_fc}, 6'b101000);
      cycle();

      set_lu();
      ex_branch_taken = 1'b1;
      #1 check("br_lu_flush0", {u1_fl, u1_cu, u1_pc}, 3'b111);
      cycle();
      nop();
      for (int i = 1; i < 4; i++) begin
         #1 check("br_flush_window", u1_fl, (i < 3) ? 1 : 0);
         cycle();
      end
      check("br_flush_count", u1_fcnt, 3);
      check("br_stall_unchanged", u1_sc, 2);
      check("br_u0_counts", {u0_sc, u0_fcnt}, {16'd1, 16'd1});

      set_lu();
      cycle();
      nop();
      mem_wait = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 check("wait_hold", {u1_ph, u1_pc, u1_ifid, u1_sc}, {3'b100, 4'd3});
         cycle();
      end
      mem_wait = 1'b0;
      #1 check("wait_resume_stall", {u1_cu, u1_pc}, 2'b10);
      cycle();
      #1 check("wait_stall_total", {u1_sc, u1_pc}, {4'd4, 1'b1});

      for (int i = 0; i < 20; i++) begin
         set_lu();
         cycle();
         nop();
         cycle();
      end
      check("sat_u1", u1_sc, 15);
      check("sat_u0", u0_sc, 22);

      ex_branch_taken = 1'b1;
      cycle();
      nop();
      drop_reset();
      #1 check("rst_mid_flush", {u1_sc, u1_fcnt, u1_fl, u1_pc}, {4'd0, 4'd0, 1'b1, 1'b0});
      reset = 1'b1;
      #1 check("rst_abort_run", {u1_pc, u1_ifid, u1_fl, u1_cu}, 4'b1100);
      cycle();

      for (int i = 0; i < 3000; i++) begin
         reset = 1'b1;
         rand_inputs();
         if ($urandom_range(0, 199) == 0) drop_reset();
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
